// File: rtl/aes_cbc_channel_arbiter.sv
// Packet-granular round-robin arbiter sharing one AES-256-CBC streaming core among N_CH channels.
// A grant is held from the first input beat until the core's output tlast beat is accepted.
module aes_cbc_channel_arbiter #(
    parameter int N_CH         = 4,
    parameter int S_AXIS_WIDTH = 8,
    parameter int M_AXIS_WIDTH = 8
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic [N_CH-1:0]                S_tvalid,
    output logic [N_CH-1:0]                S_tready,
    input  logic [N_CH*S_AXIS_WIDTH-1:0]   S_tdata,
    input  logic [N_CH-1:0]                S_tlast,
    input  logic [N_CH-1:0]                S_tuser,
    output logic                           Core_s_tvalid,
    input  logic                           Core_s_tready,
    output logic [S_AXIS_WIDTH-1:0]        Core_s_tdata,
    output logic                           Core_s_tlast,
    output logic                           Core_s_tuser,
    input  logic                           Core_m_tvalid,
    output logic                           Core_m_tready,
    input  logic [M_AXIS_WIDTH-1:0]        Core_m_tdata,
    input  logic [M_AXIS_WIDTH/8-1:0]      Core_m_tkeep,
    input  logic                           Core_m_tlast,
    output logic [N_CH-1:0]                M_tvalid,
    input  logic [N_CH-1:0]                M_tready,
    output logic [M_AXIS_WIDTH-1:0]        M_tdata,
    output logic [M_AXIS_WIDTH/8-1:0]      M_tkeep,
    output logic                           M_tlast,
    output logic [N_CH-1:0]                Grant,
    output logic                           Busy,
    output logic                           Pkt_done
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_IN   = 3'b010,
        ST_OUT  = 3'b100
    } state_t;

    state_t          state_q, state_d;
    // The current owner doubles as the round-robin pointer: both change only on IDLE->IN.
    logic [CH_W-1:0] owner_q, owner_d;
    logic [CH_W-1:0] rr_winner;
    logic            in_st, out_st, core_s_last_fire;

    function automatic logic [CH_W-1:0] rr_pick(input logic [N_CH-1:0] req,
                                                 input logic [CH_W-1:0] last);
        logic [CH_W-1:0] pick;
        int              cand;
        pick = last;
        // Walk from farthest to nearest so the first requester after the pointer wins.
        for (int i = N_CH; i >= 1; i--) begin
            cand = int'(last) + i;
            if (cand >= N_CH) cand -= N_CH;
            if (req[CH_W'(cand)]) pick = CH_W'(cand);
        end
        return pick;
    endfunction

    assign rr_winner        = rr_pick(S_tvalid, owner_q);
    assign in_st            = (state_q == ST_IN);
    assign out_st           = (state_q == ST_OUT);
    assign core_s_last_fire = Core_s_tvalid & Core_s_tready & Core_s_tlast;
    assign Busy             = in_st | out_st;
    assign Pkt_done         = out_st & Core_m_tvalid & Core_m_tready & Core_m_tlast;

    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (Rst) begin
            state_q <= ST_IDLE;
            owner_q <= LAST_CH;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through this block can infer a latch.
        state_d = state_q;
        owner_d = owner_q;
        unique case (state_q)
            ST_IDLE: if (|S_tvalid) begin
                state_d = ST_IN;
                owner_d = rr_winner;
            end
            ST_IN:   if (core_s_last_fire) state_d = ST_OUT;
            ST_OUT:  if (Pkt_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        S_tready      = '0;
        Core_s_tvalid = 1'b0;
        Core_s_tdata  = '0;
        Core_s_tlast  = 1'b0;
        Core_s_tuser  = 1'b0;
        M_tvalid      = '0;
        Core_m_tready = 1'b0;
        M_tdata       = '0;
        M_tkeep       = '0;
        M_tlast       = 1'b0;
        Grant         = '0;
        if (in_st) begin
            Core_s_tvalid     = S_tvalid[owner_q];
            Core_s_tdata      = S_tdata[int'(owner_q)*S_AXIS_WIDTH +: S_AXIS_WIDTH];
            Core_s_tlast      = S_tlast[owner_q];
            Core_s_tuser      = S_tuser[owner_q];
            S_tready[owner_q] = Core_s_tready;
        end
        // The core emits output blocks while still consuming input, so routing is live in both states.
        if (in_st || out_st) begin
            M_tvalid[owner_q] = Core_m_tvalid;
            Core_m_tready     = M_tready[owner_q];
            M_tdata           = Core_m_tdata;
            M_tkeep           = Core_m_tkeep;
            M_tlast           = Core_m_tlast;
            Grant[owner_q]    = 1'b1;
        end
    end

endmodule
